// File: rtl/sap1_sequencer.sv
// SAP-1 control sequencer: 6-T-state ring, opcode decode, bus strobes, sticky HALT.
// Optional single-step mode under `define SAP1_SINGLE_STEP_EN (adds i_step).
module sap1_sequencer #(
  parameter int OPW     = 4,
  parameter int TSTATES = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
`ifdef SAP1_SINGLE_STEP_EN
  input  logic               i_step,
`endif
  input  logic [OPW-1:0]     i_opcode,
  output logic               o_pc_inc,
  output logic               o_pc_out,
  output logic               o_mar_load,
  output logic               o_ram_out,
  output logic               o_ir_load,
  output logic               o_ir_out,
  output logic               o_a_load,
  output logic               o_a_out,
  output logic               o_alu_sub,
  output logic               o_alu_out,
  output logic               o_b_load,
  output logic               o_out_load,
  output logic [TSTATES-1:0] o_tstate,
  output logic               o_instr_done,
  output logic               o_halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef struct packed {
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  } strobe_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] dec_op;
  logic           adv;
  strobe_t        raw, gated;

`ifdef SAP1_SINGLE_STEP_EN
  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] the edge-detect history
  logic [2:0] sync_q, sync_d;
  logic       step_q, step_d;

  always_comb begin
    sync_d = {sync_q[1:0], i_step};
    step_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      step_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      step_q <= step_d;
    end
  end

  assign adv = step_q;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // T4 decodes the live IR nibble; T5/T6 use the copy captured leaving T4
  assign dec_op = (state_q == S_T4) ? i_opcode : op_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    raw     = '0;
    if (adv) begin
      case (state_q)
        S_IDLE:  if (i_run) state_d = S_T1;
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = S_T4;
        S_T4: begin
          op_d    = i_opcode;
          state_d = (i_opcode == OP_HLT) ? S_HALT : S_T5;
        end
        S_T5:    state_d = S_T6;
        S_T6:    state_d = i_run ? S_T1 : S_IDLE;
        default: state_d = S_HALT;
      endcase
    end
    case (state_q)
      S_T1: begin raw.ep = 1'b1; raw.lm = 1'b1; end
      S_T2: raw.cp = 1'b1;
      S_T3: begin raw.ce = 1'b1; raw.li = 1'b1; end
      S_T4: begin
        if (dec_op == OP_LDA || dec_op == OP_ADD || dec_op == OP_SUB) begin
          raw.ei = 1'b1;
          raw.lm = 1'b1;
        end else if (dec_op == OP_OUT) begin
          raw.ea = 1'b1;
          raw.lo = 1'b1;
        end
      end
      S_T5: begin
        if (dec_op == OP_LDA) begin
          raw.ce = 1'b1;
          raw.la = 1'b1;
        end else if (dec_op == OP_ADD || dec_op == OP_SUB) begin
          raw.ce = 1'b1;
          raw.lb = 1'b1;
        end
      end
      S_T6: begin
        if (dec_op == OP_ADD || dec_op == OP_SUB) begin
          raw.eu = 1'b1;
          raw.la = 1'b1;
          raw.su = (dec_op == OP_SUB);
        end
      end
      default: raw = '0;
    endcase
  end

  assign gated = strobe_t'(raw & {$bits(strobe_t){adv}});

  assign o_pc_inc   = gated.cp;
  assign o_pc_out   = gated.ep;
  assign o_mar_load = gated.lm;
  assign o_ram_out  = gated.ce;
  assign o_ir_load  = gated.li;
  assign o_ir_out   = gated.ei;
  assign o_a_load   = gated.la;
  assign o_a_out    = gated.ea;
  assign o_alu_sub  = gated.su;
  assign o_alu_out  = gated.eu;
  assign o_b_load   = gated.lb;
  assign o_out_load = gated.lo;

  assign o_instr_done = (state_q == S_T6) & adv;
  assign o_halted     = (state_q == S_HALT);

  always_comb begin
    o_tstate = '0;
    case (state_q)
      S_T1:    o_tstate[0] = 1'b1;
      S_T2:    o_tstate[1] = 1'b1;
      S_T3:    o_tstate[2] = 1'b1;
      S_T4:    o_tstate[3] = 1'b1;
      S_T5:    o_tstate[4] = 1'b1;
      S_T6:    o_tstate[5] = 1'b1;
      default: o_tstate = '0;
    endcase
  end

endmodule

// File: doc/sap1_sequencer.md
Name: sap1_sequencer

Overview:
- Control sequencer for the SAP-1 datapath: PC, MAR, RAM, IR, A, B, ALU and output registers sharing the 8-bit bus.
- Runs a 6-T-state ring (T1..T6) per instruction, decodes the IR opcode nibble and drives every load/enable strobe of the bus registers.
- Handles start/stop and a sticky HLT state.

Parameters:
- OPW, 4, opcode width taken from the IR upper nibble.
- TSTATES, 6, T-states per instruction; fixed, only 6 supported.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_run  input  1  1 = run; sampled at T6/IDLE boundaries.
- i_opcode  input  OPW  IR upper nibble.
- o_pc_inc  output  1  Cp: PC increment.
- o_pc_out  output  1  Ep: PC drives bus.
- o_mar_load  output  1  Lm: MAR loads bus.
- o_ram_out  output  1  CE: RAM drives bus.
- o_ir_load  output  1  Li: IR loads bus.
- o_ir_out  output  1  Ei: IR low nibble drives bus.
- o_a_load  output  1  La: accumulator loads bus.
- o_a_out  output  1  Ea: accumulator drives bus.
- o_alu_sub  output  1  Su: ALU subtract select.
- o_alu_out  output  1  Eu: ALU drives bus.
- o_b_load  output  1  Lb: B register loads bus.
- o_out_load  output  1  Lo: output register loads bus.
- o_tstate  output  6  one-hot T1..T6; 0 in IDLE/HALT.
- o_instr_done  output  1  high during T6.
- o_halted  output  1  high in HALT.

Behaviour:
- States: IDLE, T1..T6, HALT. Reset (reset=0, async) forces IDLE and clears the opcode latch; all outputs 0.
- All strobes are active-high and combinational from state plus opcode. Loads take effect on the rising edge that ends the T-state.
- IDLE -> T1 when i_run=1; otherwise stay in IDLE.
- T1->T2->T3->T4->T5->T6, one T-state per clk.
- T6 -> T1 if i_run=1, else IDLE. A deassertion of i_run mid-instruction has no effect until T6; the instruction always completes.
- Fetch: T1 Ep+Lm; T2 Cp; T3 CE+Li.
- Opcode handling: T4 decodes i_opcode directly. On the T4->T5 edge, i_opcode is latched into op_q, and T5/T6 decode op_q.
- LDA 0000: T4 Ei+Lm; T5 CE+La; T6 none.
- ADD 0001: T4 Ei+Lm; T5 CE+Lb; T6 Eu+La.
- SUB 0010: T4 Ei+Lm; T5 CE+Lb; T6 Eu+La+Su.
- OUT 1110: T4 Ea+Lo; T5, T6 none.
- HLT 1111: T4 all strobes 0; next edge -> HALT. HALT holds all strobes 0 and o_halted=1. Exit from HALT only via reset; i_run is ignored.
- Undefined opcodes: NOP, with T4..T6 strobes all 0.
- Bus exclusivity: at most one of Ep/CE/Ei/Ea/Eu is high in any cycle.

Optional Feature:
- Macro: SAP1_SINGLE_STEP_EN.
- Defined:
  - Adds input i_step (1 bit, asynchronous button).
  - i_step passes through a 2-flop synchronizer plus a rising-edge detector, producing a one-cycle step strobe 3 clk after the i_step rise.
  - State advances only on cycles with the strobe; i_run still gates IDLE->T1 and T6->T1.
  - All strobes and o_instr_done are ANDed with the step strobe, so each register loads and the PC increments exactly once per step.
  - o_tstate shows the held state continuously.
  - Reset clears the synchronizer.
- Undefined: no i_step port; advance every clk.

Test Plan:
- Reset with i_run=0 -> IDLE, all outputs 0, o_tstate=0. Raise i_run -> next cycle o_tstate=000001, o_pc_out=o_mar_load=1.
- LDA (i_opcode=0000) -> T4 Ei+Lm; T5 CE+La; T6 no strobes, o_instr_done=1; returns to T1 with o_tstate=000001.
- SUB (0010) -> T5 CE+Lb; T6 Eu+La+Su. ADD (0001) -> same T6 with Su=0. Changing i_opcode during T5/T6 does not alter the strobes.
- OUT (1110) then HLT (1111) -> Ea+Lo in OUT T4. HLT T4 strobes 0, then o_halted=1 indefinitely with i_run=1; reset=0 returns to IDLE.
- i_run dropped at T3 -> T4..T6 complete, then IDLE. Reset asserted mid-T5 -> immediate IDLE, all outputs 0, no clock needed.
- SAP1_SINGLE_STEP_EN, i_step pulse -> exactly one advance with strobes high for one clk. No pulse for 20 clk -> state held, strobes 0.
